// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer for the 8-bit instruction ROM.
// Selects a resident program, steps and branches the PC, and counts retired instructions.
module pc_sequencer #(
  parameter logic [7:0]  PROG0_BASE = 8'd0,
  parameter logic [7:0]  PROG1_BASE = 8'd100,
  parameter logic [7:0]  PROG2_BASE = 8'd152,
  parameter logic [7:0]  LAST_ADDR  = 8'd221,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       prog_sel_i,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             branch_i,
  input  logic             branchb_i,
  input  logic             cond_i,
  input  logic [7:0]       offset_i,
  output logic [7:0]       address_o,
  output logic             run_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] retired_o
);

  // state    | meaning
  // ST_IDLE  | waiting for start_i; pc holds the last halting address
  // ST_RUN   | fetching/retiring one instruction per non-stalled cycle
  // ST_FAULT | illegal select, illegal branch or out-of-range fetch; reset only
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       pc;
  logic [CNT_W-1:0] retired;
  logic             run_q;
  logic             done_q;
  logic             fault_q;

  logic [7:0]       base_addr;
  logic [8:0]       next_addr;
  logic             next_bad;
  logic             branch_clash;
  logic [CNT_W-1:0] retired_inc;

  always_comb begin
    base_addr = PROG0_BASE;
    case (prog_sel_i)
      2'd1:    base_addr = PROG1_BASE;
      2'd2:    base_addr = PROG2_BASE;
      default: base_addr = PROG0_BASE;
    endcase
  end

  // A backward branch below zero wraps to >= 256 in 9 bits, so a single
  // unsigned compare catches both underflow and overrun.
  always_comb begin
    next_addr = {1'b0, pc} + 9'd1;
    if (branch_i && cond_i)
      next_addr = {1'b0, pc} + {1'b0, offset_i};
    else if (branchb_i && cond_i)
      next_addr = {1'b0, pc} - {1'b0, offset_i};
    next_bad     = next_addr > {1'b0, LAST_ADDR};
    branch_clash = branch_i && branchb_i;
    retired_inc  = (&retired) ? retired : retired + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      pc      <= 8'd0;
      retired <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (prog_sel_i == 2'd3) begin
              state   <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state   <= ST_RUN;
              run_q   <= 1'b1;
              pc      <= base_addr;
              retired <= '0;
            end
          end
        end
        ST_RUN: begin
          if (!stall_i) begin
            retired <= retired_inc;
            if (halt_i) begin
              state  <= ST_IDLE;
              run_q  <= 1'b0;
              done_q <= 1'b1;
            end else if (branch_clash || next_bad) begin
              state   <= ST_FAULT;
              run_q   <= 1'b0;
              fault_q <= 1'b1;
            end else begin
              pc <= next_addr[7:0];
            end
          end
        end
        ST_FAULT: begin
          run_q   <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          state   <= ST_FAULT;
          run_q   <= 1'b0;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign address_o = pc;
  assign run_o     = run_q;
  assign done_o    = done_q;
  assign fault_o   = fault_q;
  assign retired_o = retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed program walks plus random stimulus
// checked against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  prog_sel_i = 2'd0;
  logic        stall_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        branchb_i = 1'b0;
  logic        cond_i = 1'b0;
  logic [7:0]  offset_i = 8'd0;
  logic [7:0]  address_o;
  logic        run_o;
  logic        done_o;
  logic        fault_o;
  logic [15:0] retired_o;

  pc_sequencer dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .prog_sel_i(prog_sel_i),
    .stall_i(stall_i), .halt_i(halt_i), .branch_i(branch_i), .branchb_i(branchb_i),
    .cond_i(cond_i), .offset_i(offset_i), .address_o(address_o), .run_o(run_o),
    .done_o(done_o), .fault_o(fault_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int addr;
    int run;
    int done;
    int fault;
    int ret;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: mode 0 idle, 1 running, 2 faulted.
  int m_mode = 0;
  int m_pc   = 0;
  int m_ret  = 0;
  int m_done = 0;
  int base_tbl[3] = '{0, 100, 152};

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_step(input int st, input int sel, input int stl, input int hlt,
                            input int br, input int brb, input int cnd, input int off);
    int nxt;
    m_done = 0;
    if (m_mode == 0) begin
      if (st != 0) begin
        if (sel == 3) m_mode = 2;
        else begin
          m_mode = 1;
          m_pc   = base_tbl[sel];
          m_ret  = 0;
        end
      end
    end else if (m_mode == 1 && stl == 0) begin
      m_ret = (m_ret >= 65535) ? 65535 : m_ret + 1;
      if (hlt != 0) begin
        m_mode = 0;
        m_done = 1;
      end else if (br != 0 && brb != 0) begin
        m_mode = 2;
      end else begin
        nxt = m_pc + 1;
        if (br != 0 && cnd != 0) nxt = m_pc + off;
        else if (brb != 0 && cnd != 0) nxt = m_pc - off;
        if (nxt < 0 || nxt > 221) m_mode = 2;
        else m_pc = nxt;
      end
    end
  endtask

  task automatic step(input bit st, input bit [1:0] sel, input bit stl, input bit hlt,
                      input bit br, input bit brb, input bit cnd, input bit [7:0] off);
    exp_t e;
    @(negedge clk_i);
    start_i = st; prog_sel_i = sel; stall_i = stl; halt_i = hlt;
    branch_i = br; branchb_i = brb; cond_i = cnd; offset_i = off;
    model_step(int'(st), int'(sel), int'(stl), int'(hlt), int'(br), int'(brb), int'(cnd), int'(off));
    e.addr  = m_pc;
    e.run   = (m_mode == 1) ? 1 : 0;
    e.done  = m_done;
    e.fault = (m_mode == 2) ? 1 : 0;
    e.ret   = m_ret;
    sb.push_back(e);
  endtask

  task automatic nop();
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  int'(address_o), 0);
    chk({tag, "_run"},   int'(run_o), 0);
    chk({tag, "_done"},  int'(done_o), 0);
    chk({tag, "_fault"}, int'(fault_o), 0);
    chk({tag, "_ret"},   int'(retired_o), 0);
  endtask

  // Assert reset between clock edges and check outputs before any edge arrives.
  task automatic reset_async(input string tag);
    @(posedge clk_i);
    #3;
    if (sb.size() != 0) begin
      $display("FAIL %s_drain: got %0d queued expected 0", tag, sb.size());
      n_err++;
      sb.delete();
    end
    start_i = 0; stall_i = 0; halt_i = 0; branch_i = 0; branchb_i = 0; cond_i = 0;
    rst_n_i = 1'b0;
    #1;
    chk_reset_vals(tag);
    m_mode = 0; m_pc = 0; m_ret = 0; m_done = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("address", int'(address_o), e.addr);
        chk("run",     int'(run_o), e.run);
        chk("done",    int'(done_o), e.done);
        chk("fault",   int'(fault_o), e.fault);
        chk("retired", int'(retired_o), e.ret);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #12;
    chk_reset_vals("por");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Program 1 walk to halt at 113.
    step(1, 2'd1, 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 13; i++) nop();
    step(0, 2'd0, 0, 1, 0, 0, 0, 8'd0);
    nop();
    nop();

    // Forward/backward branches and a backward underflow fault.
    step(1, 2'd0, 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 16; i++) nop();
    step(0, 2'd0, 0, 0, 1, 0, 1, 8'd8);
    step(0, 2'd0, 0, 0, 0, 1, 1, 8'd8);
    step(0, 2'd0, 0, 0, 1, 0, 0, 8'd8);
    step(0, 2'd0, 0, 0, 1, 0, 1, 8'd32);
    step(0, 2'd0, 0, 0, 0, 1, 1, 8'd38);
    step(0, 2'd0, 0, 0, 0, 1, 1, 8'd6);
    step(0, 2'd0, 0, 0, 0, 1, 1, 8'd9);
    nop();
    reset_async("rst_a");

    // Stall at 150, start ignored in RUN, fetch overrun past 221.
    step(1, 2'd1, 0, 0, 0, 0, 0, 8'd0);
    step(0, 2'd0, 0, 0, 1, 0, 1, 8'd50);
    step(0, 2'd0, 1, 1, 1, 0, 1, 8'd3);
    step(1, 2'd2, 1, 0, 1, 1, 1, 8'd9);
    step(0, 2'd0, 1, 0, 0, 1, 1, 8'd200);
    nop();
    step(1, 2'd0, 0, 0, 0, 0, 0, 8'd0);
    step(0, 2'd0, 0, 0, 1, 0, 1, 8'd69);
    step(0, 2'd0, 0, 0, 0, 0, 0, 8'd0);
    nop();
    reset_async("rst_b");

    // Illegal program select and self-loop with zero offset.
    step(1, 2'd3, 0, 0, 0, 0, 0, 8'd0);
    reset_async("rst_c");
    step(1, 2'd2, 0, 0, 0, 0, 0, 8'd0);
    step(0, 2'd0, 0, 0, 1, 0, 1, 8'd0);
    step(0, 2'd0, 0, 0, 1, 1, 0, 8'd0);
    reset_async("rst_d");

    for (int n = 0; n < 3000; n++) begin
      if (m_mode == 2) reset_async("rst_rand");
      else begin
        step(($urandom % 4) == 0,
             (($urandom % 16) == 0) ? 2'd3 : 2'($urandom % 3),
             ($urandom % 4) == 0,
             ($urandom % 32) == 0,
             ($urandom % 6) == 0,
             ($urandom % 6) == 0,
             1'($urandom % 2),
             8'($urandom % 12));
      end
    end
    reset_async("rst_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
